// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: instruction field layout,
// condition-code and flag encodings, and controller state encoding.
package alu_pkg;

    localparam logic [3:0] COND_AL = 4'd0;
    localparam logic [3:0] COND_EQ = 4'd1;
    localparam logic [3:0] COND_NE = 4'd2;
    localparam logic [3:0] COND_CS = 4'd3;
    localparam logic [3:0] COND_CC = 4'd4;
    localparam logic [3:0] COND_MI = 4'd5;
    localparam logic [3:0] COND_PL = 4'd6;
    localparam logic [3:0] COND_VS = 4'd7;
    localparam logic [3:0] COND_VC = 4'd8;
    localparam logic [3:0] COND_HI = 4'd9;
    localparam logic [3:0] COND_LS = 4'd10;
    localparam logic [3:0] COND_GE = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12;
    localparam logic [3:0] COND_GT = 4'd13;
    localparam logic [3:0] COND_LE = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    localparam int F_COND_HI = 31;
    localparam int F_COND_LO = 28;
    localparam int F_OP_HI   = 27;
    localparam int F_OP_LO   = 24;
    localparam int F_S       = 23;
    localparam int F_SR_HI   = 22;
    localparam int F_SR_LO   = 20;
    localparam int F_RD_HI   = 19;
    localparam int F_RD_LO   = 16;
    localparam int F_RS1_HI  = 15;
    localparam int F_RS1_LO  = 12;
    localparam int F_RS2_HI  = 11;
    localparam int F_RS2_LO  = 8;
    localparam int F_IMM_HI  = 11;
    localparam int F_IMM_LO  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2
    } state_t;

    function automatic logic [15:0] sext_imm12(input logic [11:0] imm);
        return {{4{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational condition-code evaluator: decides whether an instruction with
// the given condition executes under the given NZCV flags.
module alu_cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n_s;
    logic z_s;
    logic c_s;
    logic v_s;

    assign n_s = flags[FLG_N];
    assign z_s = flags[FLG_Z];
    assign c_s = flags[FLG_C];
    assign v_s = flags[FLG_V];

    // Condition table; NV and any unlisted code never execute.
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_AL: pass = 1'b1;
            COND_EQ: pass = z_s;
            COND_NE: pass = ~z_s;
            COND_CS: pass = c_s;
            COND_CC: pass = ~c_s;
            COND_MI: pass = n_s;
            COND_PL: pass = ~n_s;
            COND_VS: pass = v_s;
            COND_VC: pass = ~v_s;
            COND_HI: pass = c_s & ~z_s;
            COND_LS: pass = ~c_s | z_s;
            COND_GE: pass = (n_s == v_s);
            COND_LT: pass = (n_s != v_s);
            COND_GT: pass = ~z_s & (n_s == v_s);
            COND_LE: pass = z_s | (n_s != v_s);
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Initiator side of the ALU operand interface: accepts an instruction, drives
// decoded fields and register operands to the ALU, then writes back result/flags.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int NREGS   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic        ext_we,
    input  logic [3:0]  ext_waddr,
    input  logic [31:0] ext_wdata,
    output logic [31:0] alu_r1,
    output logic [31:0] alu_r2,
    output logic [3:0]  alu_op_code,
    output logic [15:0] alu_imm,
    output logic [3:0]  alu_cond,
    output logic [2:0]  alu_sr_control,
    output logic        alu_s,
    output logic [3:0]  alu_flags,
    input  logic [3:0]  alu_flg,
    input  logic [32:0] alu_out,
    output logic        retire_valid,
    output logic [3:0]  retire_rd,
    output logic [31:0] retire_data,
    output logic        retire_exec,
    output logic [3:0]  flags_o
);

    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT - 1);

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [31:0]       regs_r [NREGS];
    logic [3:0]        flags_r;
    logic [3:0]        rd_r;
    logic [31:0]       alu_r1_r;
    logic [31:0]       alu_r2_r;
    logic [3:0]        alu_op_code_r;
    logic [15:0]       alu_imm_r;
    logic [3:0]        alu_cond_r;
    logic [2:0]        alu_sr_control_r;
    logic              alu_s_r;
    logic [3:0]        alu_flags_r;
    logic              retire_valid_r;
    logic [3:0]        retire_rd_r;
    logic [31:0]       retire_data_r;
    logic              retire_exec_r;
    logic              ready_s;
    logic              accept_s;
    logic              issue_done_s;
    logic              pass_s;
    logic              unused_carry_s;

    // Carry-out reaches us only through alu_flg; the raw bit is never stored.
    assign unused_carry_s = alu_out[32];

    assign ready_s      = (state_r == ST_IDLE) & ~ext_we;
    assign accept_s     = instr_valid & ready_s;
    assign issue_done_s = (state_r == ST_ISSUE) && (cnt_r == {CNT_W{1'b0}});

    // alu_flags_r holds the flags as they stood at accept.
    alu_cond_eval u_cond_eval (
        .cond  (alu_cond_r),
        .flags (alu_flags_r),
        .pass  (pass_s)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: IDLE -> ISSUE on accept, ISSUE -> WB when the ALU latency expires.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (issue_done_s) begin
                    state_s = ST_WB;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WB:   state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Register file and status: preload in IDLE, conditional writeback at end of ISSUE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= 32'd0;
            end
            flags_r <= 4'd0;
        end else begin
            if ((state_r == ST_IDLE) && ext_we) begin
                regs_r[ext_waddr] <= ext_wdata;
            end
            if (issue_done_s && pass_s) begin
                regs_r[rd_r] <= alu_out[31:0];
                if (alu_s_r) begin
                    flags_r <= alu_flg;
                end
            end
        end
    end

    // Operand/control registers toward the ALU plus the latency counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            alu_r1_r         <= 32'd0;
            alu_r2_r         <= 32'd0;
            alu_op_code_r    <= 4'd0;
            alu_imm_r        <= 16'd0;
            alu_cond_r       <= 4'd0;
            alu_sr_control_r <= 3'd0;
            alu_s_r          <= 1'b0;
            alu_flags_r      <= 4'd0;
            rd_r             <= 4'd0;
            cnt_r            <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            alu_r1_r         <= regs_r[instr[F_RS1_HI:F_RS1_LO]];
            alu_r2_r         <= regs_r[instr[F_RS2_HI:F_RS2_LO]];
            alu_op_code_r    <= instr[F_OP_HI:F_OP_LO];
            alu_imm_r        <= sext_imm12(instr[F_IMM_HI:F_IMM_LO]);
            alu_cond_r       <= instr[F_COND_HI:F_COND_LO];
            alu_sr_control_r <= instr[F_SR_HI:F_SR_LO];
            alu_s_r          <= instr[F_S];
            alu_flags_r      <= flags_r;
            rd_r             <= instr[F_RD_HI:F_RD_LO];
            cnt_r            <= CNT_INIT;
        end else if ((state_r == ST_ISSUE) && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end
    end

    // Retirement record, pulsed valid for the single WB cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            retire_valid_r <= 1'b0;
            retire_rd_r    <= 4'd0;
            retire_data_r  <= 32'd0;
            retire_exec_r  <= 1'b0;
        end else if (issue_done_s) begin
            retire_valid_r <= 1'b1;
            retire_rd_r    <= rd_r;
            retire_data_r  <= alu_out[31:0];
            retire_exec_r  <= pass_s;
        end else begin
            retire_valid_r <= 1'b0;
        end
    end

    assign instr_ready    = ready_s;
    assign alu_r1         = alu_r1_r;
    assign alu_r2         = alu_r2_r;
    assign alu_op_code    = alu_op_code_r;
    assign alu_imm        = alu_imm_r;
    assign alu_cond       = alu_cond_r;
    assign alu_sr_control = alu_sr_control_r;
    assign alu_s          = alu_s_r;
    assign alu_flags      = alu_flags_r;
    assign retire_valid   = retire_valid_r;
    assign retire_rd      = retire_rd_r;
    assign retire_data    = retire_data_r;
    assign retire_exec    = retire_exec_r;
    assign flags_o        = flags_r;

endmodule
